// File: rtl/entropy_word_collector_if.sv
// Output word stream for entropy_word_collector: word, valid, ready.
interface entropy_word_collector_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;

  modport master (output out, output out_valid, input out_ready);
  modport slave  (input out, input out_valid, output out_ready);
endinterface

// File: rtl/entropy_word_collector.sv
// entropy_word_collector: synchronizes a raw metastable bit, samples it every
// SAMPLE_DIV cycles, debiases with a von Neumann extractor and packs WIDTH-bit
// words onto a valid/ready stream.
// Optional repetition-count health test: define ENTROPY_COLLECTOR_HEALTH_EN.
module entropy_word_collector #(
  parameter int WIDTH        = 8,
  parameter int SAMPLE_DIV   = 4,
  parameter int REPEAT_LIMIT = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       metastable,
  entropy_word_collector_if.master   m,
  output logic                       fault
);
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CNT_W = $clog2(WIDTH);
  localparam int REP_W = $clog2(REPEAT_LIMIT + 1);

  localparam logic [0:0] ST_FIRST  = 1'b0;
  localparam logic [0:0] ST_SECOND = 1'b1;

  logic             r_s1, r_s2;
  logic [DIV_W-1:0] r_div;
  logic [0:0]       r_state;
  logic             r_held;
  logic [WIDTH-1:0] r_acc;
  logic             r_acc_full;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;

  logic w_strobe, w_emit, w_xfer;

  assign w_strobe = (r_div == DIV_W'(SAMPLE_DIV - 1));
  // Unequal pair emits the first sample of the pair: 10 -> 1, 01 -> 0.
  assign w_emit   = w_strobe && (r_state == ST_SECOND) && (r_held != r_s2);
  assign w_xfer   = r_acc_full && (!r_out_valid || m.out_ready) && !fault;

  // Two-flop synchronizer; r_s2 is the raw sample source.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= metastable;
      r_s2 <= r_s1;
    end
  end

  // Sample strobe divider, wraps after SAMPLE_DIV-1.
  always_ff @(posedge clk) begin
    if (rst)           r_div <= '0;
    else if (w_strobe) r_div <= '0;
    else               r_div <= r_div + DIV_W'(1);
  end

  // Von Neumann pairing FSM; keeps running even while the accumulator is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FIRST;
      r_held  <= 1'b0;
    end else if (w_strobe) begin
      if (r_state == ST_FIRST) begin
        r_held  <= r_s2;
        r_state <= ST_SECOND;
      end else begin
        r_state <= ST_FIRST;
      end
    end
  end

  // Accumulator: first emitted bit lands in the MSB; bits dropped while full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_acc_full <= 1'b0;
      r_cnt      <= '0;
    end else if (w_xfer) begin
      r_acc_full <= 1'b0;
      r_cnt      <= '0;
    end else if (w_emit && !r_acc_full) begin
      r_acc <= {r_acc[WIDTH-2:0], r_held};
      if (r_cnt == CNT_W'(WIDTH - 1)) begin
        r_acc_full <= 1'b1;
        r_cnt      <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Output register; handshake and refill on the same edge give no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_xfer) begin
      r_out       <= r_acc;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && m.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign m.out       = r_out;
  assign m.out_valid = r_out_valid;

`ifdef ENTROPY_COLLECTOR_HEALTH_EN
  logic [REP_W-1:0] r_rep, w_rep_nxt;
  logic             r_prev, r_fault;

  // Run length including the current sample; saturates at the limit.
  always_comb begin
    w_rep_nxt = REP_W'(1);
    if (r_rep != '0 && r_s2 == r_prev)
      w_rep_nxt = (r_rep == REP_W'(REPEAT_LIMIT)) ? r_rep : r_rep + REP_W'(1);
  end

  // Repetition-count test; fault is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rep   <= '0;
      r_prev  <= 1'b0;
      r_fault <= 1'b0;
    end else if (w_strobe) begin
      r_rep  <= w_rep_nxt;
      r_prev <= r_s2;
      if (w_rep_nxt == REP_W'(REPEAT_LIMIT)) r_fault <= 1'b1;
    end
  end

  assign fault = r_fault;
`else
  logic [REP_W-1:0] w_unused_rep;
  assign w_unused_rep = REP_W'(REPEAT_LIMIT);
  assign fault        = 1'b0;
`endif
endmodule

// File: doc/entropy_word_collector.md
# entropy_word_collector

Consumer-side counterpart to the metastable-oscillator entropy sources. Samples a raw asynchronous entropy bit, debiases it with a von Neumann extractor, and assembles WIDTH-bit words presented on a valid/ready stream. It sits between a metastable oscillator output and any logic needing true-random words, e.g. seeds for lfsr instances. An optional repetition-count health test flags a stuck source.

## Interface
- WIDTH, 8: output word width in bits, at least 2.
- SAMPLE_DIV, 4: raw-sample period in clk cycles, at least 1.
- REPEAT_LIMIT, 32: consecutive identical raw samples that trip the health fault, at least 2. Only meaningful with the health test compiled in.
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- metastable  input  1  raw entropy bit; asynchronous to clk.
- out  output  WIDTH  collected random word; valid while out_valid=1.
- out_valid  output  1  word available.
- out_ready  input  1  consumer accepts word.
- fault  output  1  sticky health-test failure.

## Operation
- **Synchronizer.** Two flops (s1, s2) on metastable; s2 is the raw bit. Reset value 0.
- **Sample strobe.** Counter 0..SAMPLE_DIV-1. Strobe fires when the counter equals SAMPLE_DIV-1, then the counter wraps to 0. With SAMPLE_DIV=1 the strobe fires every cycle. On each strobe, s2 is the sample.
- **Von Neumann pairing.** Two-state FSM: FIRST and SECOND.
  - FIRST: latch the sample into `held`, go to SECOND.
  - SECOND: compare sample with `held`.
    - held=1, sample=0: emit bit 1.
    - held=0, sample=1: emit bit 0.
    - Equal: emit nothing.
  - Always return to FIRST after SECOND.
- **Accumulator.**
  - Each emitted bit shifts into acc LSB-first: acc <= {acc[WIDTH-2:0], bit}. The first bit ends up in the MSB.
  - bit count 0..WIDTH-1. When the WIDTH-th bit shifts in, acc_full is set.
  - While acc_full=1, emitted bits are discarded. The pairing FSM keeps running.
- **Output register.**
  - Transfer when acc_full && (!out_valid || out_ready) && !fault: out <= acc, out_valid <= 1, acc_full <= 0, bit count <= 0.
  - Handshake completes when out_valid && out_ready. Without a same-edge transfer, out_valid drops to 0.
  - While out_valid=1 && out_ready=0, out and out_valid hold stable.
- **Simultaneous events.**
  - Handshake plus transfer on the same edge gives back-to-back words with no bubble.
  - WIDTH-th bit arriving plus an output slot free: acc_full is set on that edge, and the transfer happens on the next edge.
- **Health test** (only with macro).
  - Repeat counter counts consecutive equal samples on strobes.
  - It resets to 1 when a sample differs from the previous one.
  - Reaching REPEAT_LIMIT sets fault. fault stays set until rst.
  - While fault=1, no new transfers occur. A word already valid remains deliverable.
- **Reset values.** out=0, out_valid=0, fault=0, acc=0, acc_full=0, bit count=0, FSM=FIRST, strobe counter=0, repeat counter=0.
- **Reset mid-operation.** rst overrides everything, including a pending handshake. A partial word is lost.

## Timing
- Synchronizer latency: 2 cycles from metastable to s2.
- Best case with SAMPLE_DIV=1: a debiased bit every 2 strobes, so a word every 2·WIDTH strobes.
  - First out_valid occurs no earlier than 2 + 2·WIDTH + 1 cycles after rst deasserts.
  - That is 19 cycles for WIDTH=8.
- out_ready may be held high permanently. out_valid is independent of out_ready combinationally; there are no combinational paths from inputs to outputs.
- fault asserts on the edge of the REPEAT_LIMIT-th identical sample.

## Configuration
- ENTROPY_COLLECTOR_HEALTH_EN defined: repetition-count test present, and fault behaves as above.
- Not defined: no repeat counter is synthesized, fault is tied to 0, and transfers never block on fault.

## Test plan
- WIDTH=8, SAMPLE_DIV=1, out_ready=1; drive metastable with the strobe-aligned pair sequence 10,01,10,10,01,01,10,01 -> one word out=8'b1011_0010, out_valid high for one cycle.
- Pairs 00 and 11 interleaved among the above 8 valid pairs -> same word 8'hB2, with later arrival (2 strobes per discarded pair).
- out_ready=0 while 3 words' worth of valid pairs arrive -> first word held stable, second held in acc (acc_full=1), third's bits discarded. Raise out_ready -> words 1 and 2 delivered back-to-back, nothing further.
- Macro defined, REPEAT_LIMIT=32, metastable held 1 -> fault=1 at the 32nd strobe, no out_valid ever. rst -> fault=0.
- Assert rst after 5 valid pairs -> all outputs 0. The next 8 pairs produce a word containing only post-reset bits.
- SAMPLE_DIV=4 -> strobes at cycles 3, 7, 11, …; metastable toggling between strobes is ignored.
